index_decode_queue: RTL and testbench

- Receiving end of the 3-bit priority-encoded request path: takes encoded indices (0..7), buffers them in order, and replays each as a one-hot strobe on the next frame tick.
- Sits between the request encoder and the unit/spawn logic, so that bursts of requests are serviced one per frame.
- Also exports a pending mask for display logic and a sticky overflow flag.

---
 rtl/index_decode_queue_if.sv | 25 ++
 rtl/index_decode_queue.sv | 78 +++++++
 tb/tb_index_decode_queue.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/index_decode_queue_if.sv
// Request/strobe bundle between the index encoder side and index_decode_queue.
// master drives requests and ticks; slave is the queue.
interface index_decode_queue_if #(
  parameter int unsigned PTR_W = 2
);
  logic             in_valid;
  logic [2:0]       in_idx;
  logic             in_ready;
  logic             tick;
  logic [7:0]       out_onehot;
  logic             out_valid;
  logic [PTR_W:0]   count;
  logic [7:0]       pending;
  logic             overflow;

  modport master (
    output in_valid, in_idx, tick,
    input  in_ready, out_onehot, out_valid, count, pending, overflow
  );

  modport slave (
    input  in_valid, in_idx, tick,
    output in_ready, out_onehot, out_valid, count, pending, overflow
  );
endinterface

// File: rtl/index_decode_queue.sv
// In-order queue of 3-bit indices replayed as one-hot strobes, one per frame tick.
// Optional macro INDEX_DUP_DROP_EN: pushes of an index already pending are consumed unstored.
module index_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  index_decode_queue_if.slave  bus
);

  localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

  logic [2:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_onehot;
  logic             r_overflow;

  logic             w_ready;
  logic             w_dup;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_pending;

  assign w_ready = (r_count != FullCount);

  always_comb begin
    w_pending = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i < int'(r_count)) w_pending[r_mem[r_head + PTR_W'(i)]] = 1'b1;
    end
  end

`ifdef INDEX_DUP_DROP_EN
  // Uses this cycle's mask, so an entry popping now still blocks its duplicate.
  assign w_dup = w_pending[bus.in_idx];
`else
  assign w_dup = 1'b0;
`endif

  assign w_push = bus.in_valid && w_ready && !w_dup;
  // Empty queue never pops, even if a push lands in the same cycle.
  assign w_pop  = bus.tick && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= bus.in_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_onehot   <= 8'h00;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      r_onehot <= w_pop ? (8'h01 << r_mem[r_head]) : 8'h00;
      if (bus.in_valid && !w_ready) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_onehot = r_onehot;
  assign bus.out_valid  = |r_onehot;
  assign bus.count      = r_count;
  assign bus.pending    = w_pending;
  assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_index_decode_queue.sv
// Self-checking bench for index_decode_queue: directed scenarios plus a random run
// against a queue-based reference model.
module tb_index_decode_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int         q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_onehot = 8'h00;

  index_decode_queue_if #(.PTR_W(PTR_W)) bus ();

  index_decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_pending();
    logic [7:0] p = 8'h00;
    foreach (q[k]) p[q[k]] = 1'b1;
    return p;
  endfunction

  // Drives one cycle of stimulus and advances the reference model; no checking here.
  task automatic step(input logic r, input logic v, input logic [2:0] idx, input logic tk);
    logic dup;
    logic pop;
    logic push;
    @(negedge clk);
    rst = r; bus.in_valid = v; bus.in_idx = idx; bus.tick = tk;
    if (r) begin
      q.delete(); m_ovf = 1'b0; m_onehot = 8'h00;
    end else begin
      dup = 1'b0;
`ifdef INDEX_DUP_DROP_EN
      foreach (q[k]) if (q[k] == int'(idx)) dup = 1'b1;
`endif
      pop  = tk && (q.size() != 0);
      push = v && (q.size() != DEPTH) && !dup;
      if (v && q.size() == DEPTH) m_ovf = 1'b1;
      m_onehot = pop ? (8'h01 << q[0]) : 8'h00;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(int'(idx));
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0; bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 3'd0, 1'b0);
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    checks++; if (bus.pending !== 8'h00) begin errors++; $display("FAIL reset_pending got %h exp 00", bus.pending); end
    checks++; if (bus.out_onehot !== 8'h00 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out got %h/%b exp 00/0", bus.out_onehot, bus.out_valid); end
    checks++; if (bus.overflow !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_flags got ovf %b rdy %b exp 0 1", bus.overflow, bus.in_ready); end
  endtask

  task automatic test_basic_order();
    logic [7:0] exp_p [3] = '{8'h20, 8'h04, 8'h80};
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd5, 1'b0);
    step(1'b0, 1'b1, 3'd2, 1'b0);
    step(1'b0, 1'b1, 3'd7, 1'b0);
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", bus.count); end
    checks++; if (bus.pending !== 8'hA4) begin errors++; $display("FAIL basic_pending got %h exp a4", bus.pending); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'd0, 1'b1);
      checks++; if (bus.out_onehot !== exp_p[i] || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL basic_pulse%0d got %h/%b exp %h/1", i, bus.out_onehot, bus.out_valid, exp_p[i]); end
    end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL basic_drain got %0d exp 0", bus.count); end
    step(1'b0, 1'b0, 3'd0, 1'b0);
    checks++; if (bus.out_onehot !== 8'h00 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pulse_end got %h/%b exp 00/0", bus.out_onehot, bus.out_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_p [4] = '{8'h02, 8'h04, 8'h08, 8'h10};
    step(1'b1, 1'b0, 3'd0, 1'b0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 3'(i), 1'b0);
    checks++; if (bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin
      errors++; $display("FAIL ovf_full got rdy %b cnt %0d exp 0 4", bus.in_ready, bus.count); end
    step(1'b0, 1'b1, 3'd6, 1'b0);
    checks++; if (bus.overflow !== 1'b1 || bus.count !== 3'd4 || bus.pending !== 8'h1E) begin
      errors++; $display("FAIL ovf_set got ovf %b cnt %0d pend %h exp 1 4 1e", bus.overflow, bus.count, bus.pending); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 3'd0, 1'b1);
      checks++; if (bus.out_onehot !== exp_p[i] || bus.overflow !== 1'b1) begin
        errors++; $display("FAIL ovf_pop%0d got %h ovf %b exp %h 1", i, bus.out_onehot, bus.overflow, exp_p[i]); end
    end
    step(1'b1, 1'b0, 3'd0, 1'b0);
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd1, 1'b0);
    step(1'b0, 1'b1, 3'd2, 1'b0);
    step(1'b0, 1'b1, 3'd3, 1'b0);
    step(1'b0, 1'b1, 3'd5, 1'b0);
    step(1'b0, 1'b1, 3'd0, 1'b1);
    checks++; if (bus.out_onehot !== 8'h02 || bus.count !== 3'd3 || bus.pending !== 8'h2C) begin
      errors++; $display("FAIL full_simul got %h cnt %0d pend %h exp 02 3 2c", bus.out_onehot, bus.count, bus.pending); end
  endtask

  task automatic test_empty_push_pop();
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd3, 1'b1);
    checks++; if (bus.out_onehot !== 8'h00 || bus.count !== 3'd1) begin
      errors++; $display("FAIL empty_simul got %h cnt %0d exp 00 1", bus.out_onehot, bus.count); end
    step(1'b0, 1'b0, 3'd0, 1'b1);
    checks++; if (bus.out_onehot !== 8'h08 || bus.count !== 3'd0) begin
      errors++; $display("FAIL empty_next got %h cnt %0d exp 08 0", bus.out_onehot, bus.count); end
  endtask

  task automatic test_wrap();
    int vals [10] = '{6, 0, 3, 7, 1, 4, 2, 5, 6, 0};
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'(vals[0]), 1'b0);
    step(1'b0, 1'b1, 3'(vals[1]), 1'b0);
    for (int i = 2; i < 12; i++) begin
      step(1'b0, i < 10, (i < 10) ? 3'(vals[i]) : 3'd0, 1'b1);
      checks++; if (bus.out_onehot !== (8'h01 << vals[i-2]) || bus.count > 3'd4) begin
        errors++; $display("FAIL wrap_pop%0d got %h cnt %0d exp %h", i - 2, bus.out_onehot, bus.count,
                           8'h01 << vals[i-2]); end
    end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", bus.count); end
  endtask

  task automatic test_dup();
`ifdef INDEX_DUP_DROP_EN
    logic [2:0] exp_cnt = 3'd2;
`else
    logic [2:0] exp_cnt = 3'd3;
`endif
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd4, 1'b0);
    step(1'b0, 1'b1, 3'd4, 1'b0);
    step(1'b0, 1'b1, 3'd1, 1'b0);
    checks++; if (bus.count !== exp_cnt || bus.pending !== 8'h12 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL dup got cnt %0d pend %h ovf %b exp %0d 12 0", bus.count, bus.pending,
                         bus.overflow, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b1, 3'd2, 1'b0);
    step(1'b0, 1'b1, 3'd5, 1'b0);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    checks++; if (bus.out_onehot !== 8'h00 || bus.out_valid !== 1'b0 || bus.count !== 3'd0 ||
                  bus.pending !== 8'h00) begin
      errors++; $display("FAIL reset_mid got %h/%b cnt %0d pend %h exp 00/0 0 00", bus.out_onehot,
                         bus.out_valid, bus.count, bus.pending); end
  endtask

  task automatic test_random();
    logic [7:0] mp;
    step(1'b1, 1'b0, 3'd0, 1'b0);
    for (int c = 0; c < 400; c++) begin
      step(1'b0, ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0));
      mp = model_pending();
      checks++;
      if (bus.out_onehot !== m_onehot || bus.out_valid !== (m_onehot != 8'h00) ||
          bus.count !== 3'(q.size()) || bus.pending !== mp || bus.overflow !== m_ovf ||
          bus.in_ready !== (q.size() != DEPTH)) begin
        errors++;
        $display("FAIL rand cyc %0d got oh %h v %b cnt %0d pend %h ovf %b rdy %b exp oh %h cnt %0d pend %h ovf %b",
                 c, bus.out_onehot, bus.out_valid, bus.count, bus.pending, bus.overflow, bus.in_ready,
                 m_onehot, q.size(), mp, m_ovf);
      end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_idx = 3'd0; bus.tick = 1'b0;
    test_reset();
    test_basic_order();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_dup();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
